// File: rtl/program_loader.sv
// Boot loader: byte stream -> big-endian words -> memory writes, holds core in reset until image is loaded.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Start,
  input  logic [7:0]  i_Byte,
  input  logic        i_ByteValid,
  output logic        o_ByteReady,
  output logic        o_MemWrite,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_WriteData,
  output logic        o_CoreRst,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Error
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS + 1);
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, LAST_WR, CHECK, RUN, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, LAST_WR, RUN, ERROR} state_t;
`endif

  state_t            state;
  logic [15:0]       len;
  logic [1:0]        byte_cnt;
  logic [IDX_W-1:0]  word_idx;
  logic [23:0]       asm_reg;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [31:0]       write_data;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic [15:0] len_next;
  logic        last_word;

  assign len_next  = {len[15:8], i_Byte};
  assign last_word = (32'(word_idx) + 32'd1) == 32'(len);

  // Status outputs are pure decodes of the state register, so ready never depends on valid.
`ifdef LOADER_CHECKSUM_EN
  assign o_ByteReady = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHECK);
  assign o_Busy      = o_ByteReady || (state == LAST_WR);
`else
  assign o_ByteReady = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign o_Busy      = o_ByteReady || (state == LAST_WR);
`endif
  assign o_CoreRst    = (state != RUN);
  assign o_Done       = (state == RUN);
  assign o_Error      = (state == ERROR);
  assign o_MemWrite   = mem_write;
  assign o_MemAddress = mem_address;
  assign o_WriteData  = write_data;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      len         <= '0;
      byte_cnt    <= '0;
      word_idx    <= '0;
      asm_reg     <= '0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      write_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      mem_write <= 1'b0;
      case (state)
        IDLE, RUN, ERROR: begin
          if (i_Start) begin
            state    <= LEN_HI;
            byte_cnt <= '0;
            word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        LEN_HI: begin
          if (i_ByteValid) begin
            len[15:8] <= i_Byte;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (i_ByteValid) begin
            len[7:0] <= i_Byte;
            if (len_next == 16'd0 || 32'(len_next) > DEPTH_LIMIT)
              state <= ERROR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (i_ByteValid) begin
            asm_reg  <= {asm_reg[15:0], i_Byte};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ i_Byte;
`endif
            // Fourth byte completes the word; the strobe goes out next cycle.
            if (byte_cnt == 2'd3) begin
              mem_write   <= 1'b1;
              write_data  <= {asm_reg, i_Byte};
              mem_address <= BASE_ADDR + 32'({word_idx, 2'b00});
              word_idx    <= word_idx + IDX_W'(1);
              if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                state <= CHECK;
`else
                state <= LAST_WR;
`endif
              end
            end
          end
        end
        LAST_WR: state <= RUN;
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (i_ByteValid)
            state <= (i_Byte == csum) ? RUN : ERROR;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (small DEPTH_WORDS so the depth boundary is cheap to hit).
module tb_program_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] write_data;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  int rel_cyc = -1;
  logic prev_core_rst = 1'b1;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  wire [5:0] flags = {core_rst, busy, done, error, byte_ready, mem_write};

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Byte(byte_in),
    .i_ByteValid(byte_valid), .o_ByteReady(byte_ready), .o_MemWrite(mem_write),
    .o_MemAddress(mem_address), .o_WriteData(write_data), .o_CoreRst(core_rst),
    .o_Busy(busy), .o_Done(done), .o_Error(error)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write log and core-release timestamp, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      wr_addr.push_back(mem_address);
      wr_data.push_back(write_data);
      last_wr_cyc = cyc;
    end
    if (prev_core_rst === 1'b1 && core_rst === 1'b0) rel_cyc = cyc;
    prev_core_rst = core_rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    byte_in    = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [31:0] w[4], output bit ok);
    bit b_ok;
    logic [7:0] x;
    logic [31:0] cur;
    x  = 8'h00;
    ok = 1'b1;
    send_byte(n[15:8], b_ok); ok = ok & b_ok;
    send_byte(n[7:0], b_ok);  ok = ok & b_ok;
    for (int i = 0; i < int'(n); i++) begin
      cur = w[i];
      for (int k = 0; k < 4; k++) begin
        x = x ^ cur[31-8*k -: 8];
        send_byte(cur[31-8*k -: 8], b_ok);
        ok = ok & b_ok;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, b_ok);
    ok = ok & b_ok;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    tick(); tick();
    checks++; if (flags !== 6'b100000) $display("[TB] FAIL reset_flags: got %b expected %b", flags, 6'b100000); else passes++;
    checks++; if ({mem_address, write_data} !== 64'h0) $display("[TB] FAIL reset_addr_data: got %h expected 0", {mem_address, write_data}); else passes++;
    rst_n = 1'b1;
    tick();
    byte_in = 8'hFF; byte_valid = 1'b1;
    tick(); tick(); tick();
    byte_valid = 1'b0;
    checks++; if (flags !== 6'b100000) $display("[TB] FAIL idle_ignores_bytes: got %b expected %b", flags, 6'b100000); else passes++;
    checks++; if (wr_addr.size() !== 0) $display("[TB] FAIL idle_no_writes: got %0d expected 0", wr_addr.size()); else passes++;
  endtask

  task automatic test_nominal();
    int base;
    bit ok;
    logic [31:0] w[4];
    base = wr_addr.size();
    w = '{32'h01020304, 32'h0A0B0C0D, 32'h0, 32'h0};
    pulse_start();
    checks++; if (flags !== 6'b110010) $display("[TB] FAIL nominal_len_hi_flags: got %b expected %b", flags, 6'b110010); else passes++;
    send_frame(16'd2, w, ok);
    tick(); tick();
    checks++; if (ok !== 1'b1) $display("[TB] FAIL nominal_accept: got %b expected 1", ok); else passes++;
    checks++; if (wr_addr.size() !== base + 2) $display("[TB] FAIL nominal_write_count: got %0d expected %0d", wr_addr.size() - base, 2); else passes++;
    checks++; if (wr_addr[base] !== BASE || wr_data[base] !== 32'h01020304) $display("[TB] FAIL nominal_word0: got %h/%h expected %h/%h", wr_addr[base], wr_data[base], BASE, 32'h01020304); else passes++;
    checks++; if (wr_addr[base+1] !== BASE + 32'd4 || wr_data[base+1] !== 32'h0A0B0C0D) $display("[TB] FAIL nominal_word1: got %h/%h expected %h/%h", wr_addr[base+1], wr_data[base+1], BASE + 32'd4, 32'h0A0B0C0D); else passes++;
    checks++; if (rel_cyc !== last_wr_cyc + 1) $display("[TB] FAIL nominal_release_timing: got cycle %0d expected %0d", rel_cyc, last_wr_cyc + 1); else passes++;
    checks++; if (flags !== 6'b001000) $display("[TB] FAIL nominal_run_flags: got %b expected %b", flags, 6'b001000); else passes++;
  endtask

  task automatic test_reload();
    int base;
    bit ok;
    logic [31:0] w[4];
    base = wr_addr.size();
    w = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
    pulse_start();
    checks++; if (flags !== 6'b110010) $display("[TB] FAIL reload_core_rst: got %b expected %b", flags, 6'b110010); else passes++;
    send_frame(16'd1, w, ok);
    tick(); tick();
    checks++; if (ok !== 1'b1 || wr_addr.size() !== base + 1) $display("[TB] FAIL reload_writes: got %0d expected 1", wr_addr.size() - base); else passes++;
    checks++; if (wr_addr[base] !== BASE || wr_data[base] !== 32'hCAFEF00D) $display("[TB] FAIL reload_word: got %h/%h expected %h/%h", wr_addr[base], wr_data[base], BASE, 32'hCAFEF00D); else passes++;
    checks++; if (flags !== 6'b001000) $display("[TB] FAIL reload_run_flags: got %b expected %b", flags, 6'b001000); else passes++;
  endtask

  task automatic test_length_errors();
    int base;
    bit ok0, ok1;
    logic [15:0] bad_len[3];
    bad_len = '{16'h0000, 16'(DEPTH + 1), 16'h0104};
    base = wr_addr.size();
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      send_byte(bad_len[i][15:8], ok0);
      send_byte(bad_len[i][7:0], ok1);
      checks++; if ((ok0 & ok1) !== 1'b1 || flags !== 6'b100100) $display("[TB] FAIL len_error_%0d_flags: got %b expected %b", i, flags, 6'b100100); else passes++;
      tick(); tick();
    end
    checks++; if (wr_addr.size() !== base) $display("[TB] FAIL len_error_no_writes: got %0d expected 0", wr_addr.size() - base); else passes++;
  endtask

  task automatic test_stalled();
    int base;
    bit ok, b_ok;
    logic [7:0] bytes[4];
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    base = wr_addr.size();
    ok = 1'b1;
    pulse_start();
    send_byte(8'h00, b_ok); ok = ok & b_ok;
    tick();
    send_byte(8'h01, b_ok); ok = ok & b_ok;
    tick();
    for (int k = 0; k < 4; k++) begin
      send_byte(bytes[k], b_ok); ok = ok & b_ok;
      if (k == 1) begin
        pulse_start();
        checks++; if ({core_rst, busy, done} !== 3'b110) $display("[TB] FAIL stall_start_ignored: got %b expected %b", {core_rst, busy, done}, 3'b110); else passes++;
      end else begin
        tick();
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, b_ok); ok = ok & b_ok;
`endif
    tick(); tick();
    checks++; if (ok !== 1'b1 || wr_addr.size() !== base + 1) $display("[TB] FAIL stall_write_count: got %0d expected 1", wr_addr.size() - base); else passes++;
    checks++; if (wr_addr[base] !== BASE || wr_data[base] !== 32'hDEADBEEF) $display("[TB] FAIL stall_word: got %h/%h expected %h/%h", wr_addr[base], wr_data[base], BASE, 32'hDEADBEEF); else passes++;
    checks++; if (flags !== 6'b001000) $display("[TB] FAIL stall_run_flags: got %b expected %b", flags, 6'b001000); else passes++;
  endtask

  task automatic test_full_depth();
    int base;
    bit ok;
    logic [31:0] w[4];
    base = wr_addr.size();
    w = '{32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004};
    pulse_start();
    send_frame(16'(DEPTH), w, ok);
    tick(); tick();
    checks++; if (ok !== 1'b1 || wr_addr.size() !== base + 4) $display("[TB] FAIL depth_write_count: got %0d expected 4", wr_addr.size() - base); else passes++;
    checks++; if (wr_addr[base+3] !== BASE + 32'hC || wr_data[base+3] !== 32'h40000004) $display("[TB] FAIL depth_last_word: got %h/%h expected %h/%h", wr_addr[base+3], wr_data[base+3], BASE + 32'hC, 32'h40000004); else passes++;
    checks++; if (wr_addr[base+2] !== BASE + 32'h8 || wr_data[base+2] !== 32'h30000003) $display("[TB] FAIL depth_word2: got %h/%h expected %h/%h", wr_addr[base+2], wr_data[base+2], BASE + 32'h8, 32'h30000003); else passes++;
    checks++; if (flags !== 6'b001000) $display("[TB] FAIL depth_run_flags: got %b expected %b", flags, 6'b001000); else passes++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok, b_ok;
    logic [7:0] frame[7];
    int base;
    for (int pass = 0; pass < 2; pass++) begin
      frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, (pass == 0) ? 8'h44 : 8'h45};
      base = wr_addr.size();
      ok = 1'b1;
      pulse_start();
      for (int k = 0; k < 7; k++) begin
        send_byte(frame[k], b_ok);
        ok = ok & b_ok;
      end
      tick(); tick();
      checks++; if (ok !== 1'b1 || wr_addr.size() !== base + 1 || wr_data[base] !== 32'h11223344) $display("[TB] FAIL csum_%0d_write: got %0d writes expected 1", pass, wr_addr.size() - base); else passes++;
      checks++; if (flags !== ((pass == 0) ? 6'b001000 : 6'b100100)) $display("[TB] FAIL csum_%0d_flags: got %b expected %b", pass, flags, (pass == 0) ? 6'b001000 : 6'b100100); else passes++;
    end
  endtask
`endif

  task automatic test_mid_load_reset();
    int base;
    bit ok, b_ok;
    logic [7:0] bytes[8];
    logic [31:0] w[4];
    bytes = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    w = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'h0, 32'h0};
    base = wr_addr.size();
    ok = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      send_byte(bytes[k], b_ok);
      ok = ok & b_ok;
    end
    rst_n = 1'b0;
    tick();
    checks++; if (flags !== 6'b100000 || {mem_address, write_data} !== 64'h0) $display("[TB] FAIL midreset_state: got %b/%h expected %b/0", flags, {mem_address, write_data}, 6'b100000); else passes++;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (ok !== 1'b1 || wr_addr.size() !== base + 1 || wr_data[base] !== 32'h11223344) $display("[TB] FAIL midreset_writes: got %0d expected 1", wr_addr.size() - base); else passes++;
    pulse_start();
    send_frame(16'd2, w, ok);
    tick(); tick();
    checks++; if (ok !== 1'b1 || wr_addr.size() !== base + 3) $display("[TB] FAIL midreset_reload_count: got %0d expected 3", wr_addr.size() - base); else passes++;
    checks++; if (wr_addr[base+1] !== BASE || wr_data[base+1] !== 32'hA1A2A3A4) $display("[TB] FAIL midreset_word0: got %h/%h expected %h/%h", wr_addr[base+1], wr_data[base+1], BASE, 32'hA1A2A3A4); else passes++;
    checks++; if (wr_addr[base+2] !== BASE + 32'd4 || wr_data[base+2] !== 32'hB1B2B3B4) $display("[TB] FAIL midreset_word1: got %h/%h expected %h/%h", wr_addr[base+2], wr_data[base+2], BASE + 32'd4, 32'hB1B2B3B4); else passes++;
    checks++; if (flags !== 6'b001000) $display("[TB] FAIL midreset_run_flags: got %b expected %b", flags, 6'b001000); else passes++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reload();
    test_length_errors();
    test_stalled();
    test_full_depth();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_mid_load_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the single-cycle core and its unified memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into memory through the memory write port at consecutive word addresses. It holds the core in reset for the whole load and releases it only after a complete, valid image is in memory.

## Interface

- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word. Matches the core's PC reset value.
- `DEPTH_WORDS`, default 256: maximum accepted image length in words.
- `i_Clk` in 1: clock.
- `i_Rst_n` in 1: reset, synchronous, active-low.
- `i_Start` in 1: single-cycle load request. Honoured only in IDLE, RUN or ERROR.
- `i_Byte` in 8: stream byte.
- `i_ByteValid` in 1: `i_Byte` is valid.
- `o_ByteReady` out 1: loader accepts a byte. Transfer happens on a rising edge with valid and ready both high.
- `o_MemWrite` out 1: one-cycle memory write strobe.
- `o_MemAddress` out 32: write byte address.
- `o_WriteData` out 32: write word.
- `o_CoreRst` out 1: active-high reset to the core.
- `o_Busy` out 1: load in progress.
- `o_Done` out 1: image loaded; core running.
- `o_Error` out 1: load aborted.

## Operation

- **Frame format:** 2 length bytes (N, 16-bit, MSB first), then 4·N data bytes. Each word is sent MSB first, so byte 0 lands in bits [31:24] (the opcode field). With checksum enabled, one checksum byte follows.
- **States:** IDLE, LEN_HI, LEN_LO, DATA, LAST_WR, CHECK (macro only), RUN, ERROR.
- **IDLE:**
  - `o_CoreRst`=1; all other outputs 0.
  - `i_Start` moves to LEN_HI.
- **LEN_HI, LEN_LO:**
  - `o_ByteReady`=1; latch the length bytes.
  - After LEN_LO, if N=0 or N>`DEPTH_WORDS`, go to ERROR. Otherwise go to DATA.
- **DATA:**
  - `o_ByteReady`=1. A 2-bit byte counter shifts bytes into a 32-bit assembly register.
  - On acceptance of the 4th byte of word i, register `o_WriteData` = word and `o_MemAddress` = `BASE_ADDR` + 4·i. Pulse `o_MemWrite` in the next cycle.
  - Word index width: ceil(log2(`DEPTH_WORDS`+1)). Address arithmetic is 32-bit and wraps modulo 2^32.
  - After the last word's 4th byte, go to LAST_WR. With the macro, go to CHECK instead.
- **LAST_WR:**
  - `o_ByteReady`=0. The final write pulse occurs in this cycle.
  - Next state is RUN.
- **RUN:**
  - `o_CoreRst`=0, `o_Done`=1, `o_ByteReady`=0.
  - `i_Start` moves to LEN_HI and re-asserts `o_CoreRst` from the next cycle.
- **ERROR:**
  - `o_Error`=1, `o_CoreRst`=1, `o_ByteReady`=0. No further writes.
  - `i_Start` moves to LEN_HI.
- `o_Busy`=1 in LEN_HI, LEN_LO, DATA, LAST_WR and CHECK.
- `i_Start` is ignored while busy.
- Bytes presented while `o_ByteReady`=0 are not consumed.
- Words already written before an abort stay in memory.

## Timing

- **Reset** (`i_Rst_n`=0 at an edge), including mid-load:
  - Next state is IDLE; byte counter, word index and checksum are cleared.
  - `o_CoreRst`=1; `o_MemWrite`, `o_ByteReady`, `o_Busy`, `o_Done`, `o_Error`, `o_MemAddress`, `o_WriteData` = 0.
  - A pending write pulse is dropped.
- All outputs are registered or decoded from the state register. There is no combinational path from `i_ByteValid` to `o_ByteReady`.
- **Throughput:** one byte per cycle sustained. The write pulse for word i overlaps acceptance of the first byte of word i+1.
- **Write latency:** `o_MemWrite` is high exactly one cycle, the cycle after the 4th byte is accepted. Address and data are stable in that cycle.
- **Core release:** `o_CoreRst` falls in the cycle after the last write pulse (no macro), or in the cycle after the checksum byte is accepted (macro). It never falls before the last write pulse.
- Gaps in `i_ByteValid` stall the FSM indefinitely with no timeout.

## Configuration

- **`LOADER_CHECKSUM_EN` defined:**
  - Running XOR over all 4·N data bytes. Length bytes are excluded.
  - CHECK state: `o_ByteReady`=1; accept one byte.
  - Match → RUN; mismatch → ERROR.
  - The final write pulse coincides with the first CHECK cycle.
- **Undefined:** CHECK state and XOR register are absent. DATA → LAST_WR → RUN.

## Test plan

- **Nominal load:** `i_Start`, then N=2, words 32'h01020304, 32'h0A0B0C0D streamed back-to-back → writes at 0x0 and 0x4 with those values, each pulse one cycle. `o_CoreRst` falls one cycle after the second pulse. `o_Done`=1.
- **Length errors:** N=0 → ERROR after LEN_LO with no writes. N=`DEPTH_WORDS`+1 → ERROR. `o_CoreRst` stays 1 in both cases.
- **Stalled stream:** `i_ByteValid` toggled every other cycle for N=1, word 32'hDEADBEEF → a single write of 32'hDEADBEEF at `BASE_ADDR`, one pulse only.
- **Checksum (macro):** N=1, word 32'h11223344, checksum 8'h44 → RUN. Same frame with checksum 8'h45 → ERROR and `o_CoreRst` held at 1.
- **Mid-load reset:** `i_Rst_n` low after 6 data bytes of N=2 → next cycle IDLE, no further `o_MemWrite`. A new `i_Start` plus a full frame loads correctly from `BASE_ADDR`.
- **Reload from RUN:** after a successful load, `i_Start` → `o_CoreRst`=1 next cycle and a new image is written starting at `BASE_ADDR`.
